// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// States, owner encodings and the legal WAIT_CYCLES range.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } arb_state_t;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_D  = 1'b1;

   localparam int unsigned WAIT_CYCLES_MIN = 1;
   localparam int unsigned WAIT_CYCLES_MAX = 15;

endpackage

// File: rtl/mem_arb_wait_cnt.sv
// Loadable wait-state up-counter; o_tc flags that the count has reached WAIT_CYCLES.
module mem_arb_wait_cnt
   import mem_arb_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               i_load,
   input  logic [$clog2(WAIT_CYCLES+1)-1:0]   i_ld_val,
   input  logic                               i_inc,
   output logic [$clog2(WAIT_CYCLES+1)-1:0]   o_cnt,
   output logic                               o_tc
);

   localparam int unsigned CNT_W = $clog2(WAIT_CYCLES + 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_ld_val;
      end else if (i_inc) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;
   assign o_tc  = (r_cnt == CNT_W'(WAIT_CYCLES));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requesters onto one single-port memory with fixed wait states.
// Define MEM_ARB_RR_EN for round-robin tie-break; default is data-wins fixed priority.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              owner
);

   localparam int unsigned CNT_W = $clog2(WAIT_CYCLES + 1);

   if (WAIT_CYCLES < WAIT_CYCLES_MIN || WAIT_CYCLES > WAIT_CYCLES_MAX) begin : g_bad_wait
      $error("mem_port_arbiter: WAIT_CYCLES out of range 1..15");
   end

   arb_state_t        r_state;
   arb_state_t        w_next;
   logic              r_owner;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_if_rdata;
   logic [DATA_W-1:0] r_d_rdata;
   logic              w_grant;
   logic              w_pick_d;
   logic              w_inc;
   logic              w_tc;
   logic              w_capture;
   logic [CNT_W-1:0]  w_cnt;

   always_comb begin : p_arb
`ifdef MEM_ARB_RR_EN
      // Tie goes to whichever requester was not served last.
      w_pick_d = d_req & (~if_req | (r_owner == OWN_IF));
`else
      w_pick_d = d_req;
`endif
      w_grant   = (r_state == ST_IDLE) & (if_req | d_req);
      w_inc     = (r_state == ST_ACCESS) & ~w_tc;
      w_capture = (r_state == ST_ACCESS) & w_tc & ~r_we;
   end

   mem_arb_wait_cnt #(
      .WAIT_CYCLES(WAIT_CYCLES)
   ) u_wait_cnt (
      .clk      (clk),
      .reset    (reset),
      .i_load   (w_grant),
      .i_ld_val (CNT_W'(1)),
      .i_inc    (w_inc),
      .o_cnt    (w_cnt),
      .o_tc     (w_tc)
   );

   always_ff @(posedge clk) begin : p_state
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin : p_next
      w_next = ST_IDLE;
      case (r_state)
         ST_IDLE:   w_next = (if_req | d_req) ? ST_ACCESS : ST_IDLE;
         ST_ACCESS: w_next = w_tc ? ST_DONE : ST_ACCESS;
         ST_DONE:   w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   always_comb begin : p_out
      mem_en = 1'b0;
      mem_we = 1'b0;
      if_ack = 1'b0;
      d_ack  = 1'b0;
      busy   = 1'b0;
      case (r_state)
         ST_ACCESS: begin
            mem_en = 1'b1;
            mem_we = r_we;
            busy   = 1'b1;
         end
         ST_DONE: begin
            busy   = 1'b1;
            if_ack = (r_owner == OWN_IF);
            d_ack  = (r_owner == OWN_D);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin : p_capture
      if (reset) begin
         r_owner    <= OWN_IF;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_if_rdata <= '0;
         r_d_rdata  <= '0;
      end else begin
         if (w_grant) begin
            r_owner <= w_pick_d ? OWN_D : OWN_IF;
            r_we    <= w_pick_d & d_we;
            r_addr  <= w_pick_d ? d_addr : if_addr;
            r_wdata <= w_pick_d ? d_wdata : '0;
         end
         if (w_capture) begin
            if (r_owner == OWN_D) r_d_rdata  <= mem_rdata;
            else                  r_if_rdata <= mem_rdata;
         end
      end
   end

   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign if_rdata  = r_if_rdata;
   assign d_rdata   = r_d_rdata;
   assign owner     = r_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of single accesses plus tie, hold, reset and latency sequences.
module tb_mem_port_arbiter;

   localparam int unsigned W = 2;

   logic        clk;
   logic        reset;
   logic        if_req, if_ack, d_req, d_we, d_ack;
   logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
   logic        mem_en, mem_we, busy, owner;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   logic        a_if_req, a_if_ack, a_d_ack, a_mem_en, a_mem_we, a_busy, a_owner;
   logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata;
   logic        b_if_req, b_if_ack, b_d_ack, b_mem_en, b_mem_we, b_busy, b_owner;
   logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;

   int n_chk = 0;
   int n_err = 0;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) dut_w1 (
      .clk(clk), .reset(reset),
      .if_req(a_if_req), .if_addr(32'h80), .if_ack(a_if_ack), .if_rdata(a_if_rdata),
      .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
      .d_ack(a_d_ack), .d_rdata(a_d_rdata),
      .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
      .mem_rdata(32'h1111_0001), .busy(a_busy), .owner(a_owner)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(15)) dut_w15 (
      .clk(clk), .reset(reset),
      .if_req(b_if_req), .if_addr(32'h84), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
      .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
      .d_ack(b_d_ack), .d_rdata(b_d_rdata),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
      .mem_rdata(32'hF0F0_000F), .busy(b_busy), .owner(b_owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: read data is only valid in the W-th cycle of a held access.
   logic [31:0] mem [256];
   logic        mem_load;
   int unsigned hold;

   always @(posedge clk) begin
      if (mem_load) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
         mem[8'h10] <= 32'h2010_0005;
         mem[8'h11] <= 32'h1234_5678;
         mem[8'h80] <= 32'hCAFE_F00D;
      end else if (mem_en && mem_we && hold == W - 1) begin
         mem[mem_addr[9:2]] <= mem_wdata;
      end
      hold <= mem_en ? hold + 1 : 0;
   end

   assign mem_rdata = (mem_en && !mem_we && hold == W - 1) ? mem[mem_addr[9:2]] : 32'hBAD0_BAD0;

   typedef struct {
      logic        is_d;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_if;
      logic [31:0] exp_d;
   } vec_t;

   vec_t tv[8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic do_access(input int idx, input vec_t v);
      nxt();
      if (v.is_d) begin
         d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
      end else begin
         if_req = 1'b1; if_addr = v.addr;
      end
      for (int c = 1; c <= int'(W) + 1; c++) begin
         nxt();
         if (c <= int'(W)) begin
            chk1($sformatf("v%0d_c%0d_mem_en", idx, c), mem_en, 1'b1);
            chk1($sformatf("v%0d_c%0d_mem_we", idx, c), mem_we, v.is_d & v.we);
            chk($sformatf("v%0d_c%0d_mem_addr", idx, c), mem_addr, v.addr);
            chk1($sformatf("v%0d_c%0d_ack", idx, c), if_ack | d_ack, 1'b0);
            if (c == 1) begin
               chk1($sformatf("v%0d_owner", idx), owner, v.is_d);
               if (v.is_d && v.we) chk($sformatf("v%0d_mem_wdata", idx), mem_wdata, v.wdata);
               // Inputs change mid-access; latched copies must be unaffected.
               if_addr = v.addr ^ 32'h0000_0FF0;
               d_addr  = v.addr ^ 32'h0000_0FF0;
               d_wdata = ~v.wdata;
            end
         end else begin
            chk1($sformatf("v%0d_done_mem_en", idx), mem_en, 1'b0);
            chk1($sformatf("v%0d_if_ack", idx), if_ack, ~v.is_d);
            chk1($sformatf("v%0d_d_ack", idx), d_ack, v.is_d);
            chk($sformatf("v%0d_if_rdata", idx), if_rdata, v.exp_if);
            chk($sformatf("v%0d_d_rdata", idx), d_rdata, v.exp_d);
            if_req = 1'b0;
            d_req  = 1'b0;
         end
      end
      nxt();
      chk1($sformatf("v%0d_idle_busy", idx), busy, 1'b0);
   endtask

   int lat;

   initial begin
      tv[0] = '{1'b0, 1'b0, 32'h040, 32'h0,         32'h2010_0005, 32'h0};
      tv[1] = '{1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'h2010_0005, 32'h0};
      tv[2] = '{1'b1, 1'b0, 32'h100, 32'h0,         32'h2010_0005, 32'hDEAD_BEEF};
      tv[3] = '{1'b0, 1'b0, 32'h044, 32'h0,         32'h1234_5678, 32'hDEAD_BEEF};
      tv[4] = '{1'b1, 1'b0, 32'h200, 32'h0,         32'h1234_5678, 32'hCAFE_F00D};
      tv[5] = '{1'b1, 1'b1, 32'h200, 32'h0BAD_CAFE, 32'h1234_5678, 32'hCAFE_F00D};
      tv[6] = '{1'b1, 1'b0, 32'h200, 32'h0,         32'h1234_5678, 32'h0BAD_CAFE};
      tv[7] = '{1'b0, 1'b0, 32'h100, 32'h0,         32'hDEAD_BEEF, 32'h0BAD_CAFE};

      reset = 1'b1; mem_load = 1'b1;
      if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      a_if_req = 1'b0; b_if_req = 1'b0;
      repeat (3) nxt();
      reset = 1'b0; mem_load = 1'b0;
      nxt();
      chk1("rst_mem_en", mem_en, 1'b0);
      chk1("rst_mem_we", mem_we, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_owner", owner, 1'b0);
      chk1("rst_acks", if_ack | d_ack, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_if_rdata", if_rdata, 32'h0);
      chk("rst_d_rdata", d_rdata, 32'h0);

      for (int i = 0; i < 8; i++) do_access(i, tv[i]);

      // Tie: data first, fetch granted in the IDLE cycle after d_ack.
      nxt();
      if_req = 1'b1; if_addr = 32'h040; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
      nxt(); chk1("tieA_c1_owner", owner, 1'b1); chk("tieA_c1_addr", mem_addr, 32'h200);
      nxt();
      nxt(); chk1("tieA_c3_d_ack", d_ack, 1'b1); chk1("tieA_c3_if_ack", if_ack, 1'b0);
      chk("tieA_c3_d_rdata", d_rdata, 32'h0BAD_CAFE);
      d_req = 1'b0;
      nxt(); chk1("tieA_c4_busy", busy, 1'b0);
      nxt(); chk1("tieA_c5_owner", owner, 1'b0); chk("tieA_c5_addr", mem_addr, 32'h040);
      chk1("tieA_c5_mem_en", mem_en, 1'b1);
      nxt();
      nxt(); chk1("tieA_c7_if_ack", if_ack, 1'b1); chk("tieA_c7_if_rdata", if_rdata, 32'h2010_0005);
      if_req = 1'b0;
      nxt();

      // Second tie arises with owner = data (data re-requests straight after its ack).
      nxt();
      if_req = 1'b1; if_addr = 32'h044; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
      nxt(); chk1("tieB_c1_owner", owner, 1'b1);
      nxt();
      nxt(); chk1("tieB_c3_d_ack", d_ack, 1'b1);
      nxt(); chk1("tieB_c4_busy", busy, 1'b0);
      nxt();
`ifdef MEM_ARB_RR_EN
      chk1("tieB_c5_owner", owner, 1'b0); chk("tieB_c5_addr", mem_addr, 32'h044);
      d_req = 1'b0;
      nxt();
      nxt(); chk1("tieB_c7_if_ack", if_ack, 1'b1); chk("tieB_c7_if_rdata", if_rdata, 32'h1234_5678);
      if_req = 1'b0;
`else
      chk1("tieB_c5_owner", owner, 1'b1); chk("tieB_c5_addr", mem_addr, 32'h200);
      d_req = 1'b0;
      nxt();
      nxt(); chk1("tieB_c7_d_ack", d_ack, 1'b1); chk1("tieB_c7_if_ack", if_ack, 1'b0);
      nxt();
      nxt(); chk1("tieB_c9_owner", owner, 1'b0); chk("tieB_c9_addr", mem_addr, 32'h044);
      nxt();
      nxt(); chk1("tieB_c11_if_ack", if_ack, 1'b1); chk("tieB_c11_if_rdata", if_rdata, 32'h1234_5678);
      if_req = 1'b0;
`endif
      nxt();

      // Fetch request held one cycle past ack starts a second access.
      nxt();
      if_req = 1'b1; if_addr = 32'h040;
      nxt(); nxt();
      nxt(); chk1("hold_c3_ack", if_ack, 1'b1);
      nxt(); chk1("hold_c4_ack", if_ack, 1'b0); chk1("hold_c4_busy", busy, 1'b0);
      nxt(); chk1("hold_c5_busy", busy, 1'b1); chk1("hold_c5_ack", if_ack, 1'b0);
      if_req = 1'b0;
      nxt(); chk1("hold_c6_ack", if_ack, 1'b0);
      nxt(); chk1("hold_c7_ack", if_ack, 1'b1);
      nxt(); chk1("hold_c8_ack", if_ack, 1'b0);

      // Reset in cycle 2 of a load aborts it without an ack.
      nxt();
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
      nxt(); chk1("rstmid_c1_mem_en", mem_en, 1'b1);
      nxt(); reset = 1'b1; d_req = 1'b0;
      nxt();
      reset = 1'b0;
      chk1("rstmid_mem_en", mem_en, 1'b0);
      chk1("rstmid_busy", busy, 1'b0);
      chk1("rstmid_owner", owner, 1'b0);
      chk("rstmid_d_rdata", d_rdata, 32'h0);
      chk("rstmid_if_rdata", if_rdata, 32'h0);
      chk("rstmid_mem_addr", mem_addr, 32'h0);
      for (int k = 0; k < 4; k++) begin
         chk1($sformatf("rstmid_no_ack%0d", k), d_ack, 1'b0);
         nxt();
      end
      do_access(8, '{1'b1, 1'b0, 32'h200, 32'h0, 32'h0, 32'h0BAD_CAFE});

      // Latency at the WAIT_CYCLES extremes.
      nxt();
      a_if_req = 1'b1;
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         nxt();
         if (a_if_ack) begin lat = k; break; end
      end
      a_if_req = 1'b0;
      chk("w1_latency", lat, 2);
      chk("w1_if_rdata", a_if_rdata, 32'h1111_0001);

      nxt();
      b_if_req = 1'b1;
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         nxt();
         if (b_if_ack) begin lat = k; break; end
      end
      b_if_req = 1'b0;
      chk("w15_latency", lat, 16);
      chk("w15_if_rdata", b_if_rdata, 32'hF0F0_000F);

      nxt();
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
